cpu_datapath: RTL and testbench

// 32-bit single-bus datapath of the multi-cycle RISC CPU. One shared bus links the
// 16 GPRs, HI, LO, PC, IR, Y, Z (64-bit), MAR, MDR and the ALU. The external control

---
 rtl/cpu_datapath.sv | 142 ++++++++++++++
 tb/tb_cpu_datapath.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_datapath.sv
// Single-bus 32-bit datapath for the multi-cycle RISC CPU: register file, special registers,
// a priority bus mux and a combinational ALU feeding the 64-bit Z register.
module cpu_datapath (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] gpr_in,
    input  logic [15:0] gpr_out,
    input  logic        hi_in,
    input  logic        lo_in,
    input  logic        hi_out,
    input  logic        lo_out,
    input  logic        pc_in,
    input  logic        pc_out,
    input  logic        ir_in,
    input  logic        z_in,
    input  logic        z_high_out,
    input  logic        z_low_out,
    input  logic        inport_out,
    input  logic        c_out,
    input  logic        y_in,
    input  logic        mar_in,
    input  logic        mdr_in,
    input  logic        mdr_out,
    input  logic        read,
    input  logic [31:0] m_data_in,
    input  logic [3:0]  alu_op,
    input  logic        inc_pc,
    output logic [31:0] bus_data
);

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0011,
        OP_SHR = 4'b0100,
        OP_SHL = 4'b0101,
        OP_ROR = 4'b0110,
        OP_ROL = 4'b0111,
        OP_MUL = 4'b1000,
        OP_DIV = 4'b1001,
        OP_NEG = 4'b1010,
        OP_NOT = 4'b1011
    } alu_op_e;

    logic [31:0] gpr [16];
    logic [31:0] hi_q, lo_q, pc_q, ir_q, y_q, mar_q, mdr_q;
    logic [63:0] z_q;
    logic [31:0] bus;
    logic [31:0] c_val;
    logic [63:0] alu_result;

    assign c_val    = {{13{ir_q[18]}}, ir_q[18:0]};
    assign bus_data = bus;

    // Later assignments win, so the list is written from lowest to highest priority.
    always_comb begin
        bus = '0;
        if (c_out)      bus = c_val;
        if (inport_out) bus = 32'h0;
        if (mdr_out)    bus = mdr_q;
        if (pc_out)     bus = pc_q;
        if (z_low_out)  bus = z_q[31:0];
        if (z_high_out) bus = z_q[63:32];
        if (lo_out)     bus = lo_q;
        if (hi_out)     bus = hi_q;
        for (int i = 15; i >= 0; i--) begin
            if (gpr_out[i]) bus = gpr[i];
        end
    end

    logic [31:0]        op_a, op_b, div_b, quot, rem;
    logic [4:0]         sh;
    logic [63:0]        dbl, dbl_rol;
    logic signed [63:0] prod;
    logic               div_ovf;

    assign op_a    = inc_pc ? 32'd1 : y_q;
    assign op_b    = bus;
    assign sh      = op_b[4:0];
    assign dbl     = {op_a, op_a};
    assign dbl_rol = dbl << sh;
    assign prod    = $signed({{32{op_a[31]}}, op_a}) * $signed({{32{op_b[31]}}, op_b});
    // The divider never sees zero or the one overflowing pair; those results are patched below.
    assign div_ovf = (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
    assign div_b   = ((op_b == 32'h0) || div_ovf) ? 32'd1 : op_b;
    assign quot    = $signed(op_a) / $signed(div_b);
    assign rem     = $signed(op_a) % $signed(div_b);

    always_comb begin
        alu_result = '0;
        case (alu_op_e'(alu_op))
            OP_AND: alu_result = {32'h0, op_a & op_b};
            OP_OR:  alu_result = {32'h0, op_a | op_b};
            OP_ADD: alu_result = {32'h0, op_a + op_b};
            OP_SUB: alu_result = {32'h0, op_a - op_b};
            OP_SHR: alu_result = {32'h0, op_a >> sh};
            OP_SHL: alu_result = {32'h0, op_a << sh};
            OP_ROR: alu_result = {32'h0, dbl[31:0] >> sh | dbl[63:32] << (6'd32 - {1'b0, sh})};
            OP_ROL: alu_result = {32'h0, dbl_rol[63:32]};
            OP_MUL: alu_result = prod;
            OP_DIV: begin
                if (op_b == 32'h0)
                    alu_result = {op_a, 32'h0};
                else if (div_ovf)
                    alu_result = {32'h0, op_a};
                else
                    alu_result = {rem, quot};
            end
            OP_NEG: alu_result = {32'h0, -op_b};
            OP_NOT: alu_result = {32'h0, ~op_b};
            default: alu_result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) gpr[i] <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            pc_q  <= '0;
            ir_q  <= '0;
            y_q   <= '0;
            z_q   <= '0;
            mar_q <= '0;
            mdr_q <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (gpr_in[i]) gpr[i] <= bus;
            end
            if (hi_in)  hi_q  <= bus;
            if (lo_in)  lo_q  <= bus;
            if (pc_in)  pc_q  <= bus;
            if (ir_in)  ir_q  <= bus;
            if (y_in)   y_q   <= bus;
            if (mar_in) mar_q <= bus;
            if (mdr_in) mdr_q <= read ? m_data_in : bus;
            if (z_in)   z_q   <= alu_result;
        end
    end

endmodule

// File: tb/tb_cpu_datapath.sv
// Bench for cpu_datapath: directed register-transfer sequences followed by random strobe
// patterns, all checked on the bus against a behavioural register-transfer model.
module tb_cpu_datapath;

    logic        clk;
    logic        reset_n;
    logic [15:0] gpr_in, gpr_out;
    logic        hi_in, lo_in, hi_out, lo_out, pc_in, pc_out, ir_in, z_in;
    logic        z_high_out, z_low_out, inport_out, c_out, y_in, mar_in, mdr_in, mdr_out, read;
    logic [31:0] m_data_in;
    logic [3:0]  alu_op;
    logic        inc_pc;
    logic [31:0] bus_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_r [16];
    logic [31:0] m_hi, m_lo, m_pc, m_ir, m_y, m_mar, m_mdr;
    logic [63:0] m_z;

    cpu_datapath dut (
        .clk(clk), .reset_n(reset_n),
        .gpr_in(gpr_in), .gpr_out(gpr_out),
        .hi_in(hi_in), .lo_in(lo_in), .hi_out(hi_out), .lo_out(lo_out),
        .pc_in(pc_in), .pc_out(pc_out), .ir_in(ir_in), .z_in(z_in),
        .z_high_out(z_high_out), .z_low_out(z_low_out), .inport_out(inport_out),
        .c_out(c_out), .y_in(y_in), .mar_in(mar_in), .mdr_in(mdr_in),
        .mdr_out(mdr_out), .read(read), .m_data_in(m_data_in),
        .alu_op(alu_op), .inc_pc(inc_pc), .bus_data(bus_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_r[i] = '0;
        m_hi = '0; m_lo = '0; m_pc = '0; m_ir = '0;
        m_y = '0; m_mar = '0; m_mdr = '0; m_z = '0;
    endtask

    function automatic logic [31:0] model_bus();
        for (int i = 0; i < 16; i++) if (gpr_out[i]) return m_r[i];
        if (hi_out)     return m_hi;
        if (lo_out)     return m_lo;
        if (z_high_out) return m_z[63:32];
        if (z_low_out)  return m_z[31:0];
        if (pc_out)     return m_pc;
        if (mdr_out)    return m_mdr;
        if (inport_out) return 32'h0;
        if (c_out)      return {{13{m_ir[18]}}, m_ir[18:0]};
        return 32'h0;
    endfunction

    // Plain-arithmetic ALU reference; rotates are done one bit at a time.
    function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int          sa = a;
        int          sb = b;
        int          n  = int'(b % 32);
        logic [31:0] r  = a;
        longint      p;
        case (op)
            4'd0:  return {32'h0, a & b};
            4'd1:  return {32'h0, a | b};
            4'd2:  return {32'h0, a + b};
            4'd3:  return {32'h0, a - b};
            4'd4:  return {32'h0, a >> n};
            4'd5:  return {32'h0, a << n};
            4'd6:  begin repeat (n) r = {r[0], r[31:1]}; return {32'h0, r}; end
            4'd7:  begin repeat (n) r = {r[30:0], r[31]}; return {32'h0, r}; end
            4'd8:  begin p = longint'(sa) * longint'(sb); return p; end
            4'd9:  begin
                if (sb == 0) return {a, 32'h0};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            4'd10: return {32'h0, 32'h0 - b};
            4'd11: return {32'h0, ~b};
            default: return 64'h0;
        endcase
    endfunction

    task automatic clear_strobes();
        gpr_in = '0; gpr_out = '0;
        hi_in = 0; lo_in = 0; hi_out = 0; lo_out = 0; pc_in = 0; pc_out = 0;
        ir_in = 0; z_in = 0; z_high_out = 0; z_low_out = 0; inport_out = 0;
        c_out = 0; y_in = 0; mar_in = 0; mdr_in = 0; mdr_out = 0; read = 0;
        m_data_in = '0; alu_op = '0; inc_pc = 0;
    endtask

    // One clock: check the bus against the model, then advance the model across the edge.
    task automatic apply_stimulus(input string tag);
        logic [31:0] eb;
        logic [63:0] ea;
        #1;
        eb = model_bus();
        check_output(tag, bus_data, eb);
        ea = ref_alu(alu_op, inc_pc ? 32'd1 : m_y, eb);
        @(posedge clk);
        for (int i = 0; i < 16; i++) if (gpr_in[i]) m_r[i] = eb;
        if (hi_in)  m_hi  = eb;
        if (lo_in)  m_lo  = eb;
        if (pc_in)  m_pc  = eb;
        if (ir_in)  m_ir  = eb;
        if (y_in)   m_y   = eb;
        if (mar_in) m_mar = eb;
        if (mdr_in) m_mdr = read ? m_data_in : eb;
        if (z_in)   m_z   = ea;
        #1;
    endtask

    task automatic expect_bus(input string tag, input logic [31:0] val);
        #1;
        check_output(tag, bus_data, val);
    endtask

    task automatic load_mdr(input logic [31:0] val);
        clear_strobes(); m_data_in = val; read = 1; mdr_in = 1;
        apply_stimulus("mdr_load");
    endtask

    task automatic load_gpr(input int idx, input logic [31:0] val);
        load_mdr(val);
        clear_strobes(); mdr_out = 1; gpr_in[idx] = 1;
        apply_stimulus("gpr_load");
        clear_strobes(); gpr_out[idx] = 1;
        expect_bus($sformatf("r%0d_value", idx), val);
        apply_stimulus("gpr_read");
    endtask

    task automatic load_y(input logic [31:0] val);
        load_mdr(val);
        clear_strobes(); mdr_out = 1; y_in = 1;
        apply_stimulus("y_load");
    endtask

    task automatic alu_from_mdr(input logic [3:0] op, input logic [31:0] b);
        load_mdr(b);
        clear_strobes(); mdr_out = 1; alu_op = op; z_in = 1;
        apply_stimulus("alu_op");
    endtask

    task automatic read_z(input string tag, input logic [31:0] hi_exp, input logic [31:0] lo_exp);
        clear_strobes(); z_high_out = 1;
        expect_bus({tag, "_zhi"}, hi_exp);
        apply_stimulus("z_high");
        clear_strobes(); z_low_out = 1;
        expect_bus({tag, "_zlo"}, lo_exp);
        apply_stimulus("z_low");
    endtask

    task automatic drive_source(input int k);
        if (k < 16) gpr_out[k] = 1;
        else case (k)
            16: hi_out = 1;
            17: lo_out = 1;
            18: z_high_out = 1;
            19: z_low_out = 1;
            20: pc_out = 1;
            21: mdr_out = 1;
            22: inport_out = 1;
            23: c_out = 1;
            default: ;
        endcase
    endtask

    initial begin
        logic [31:0] eb, a;
        model_reset();
        clear_strobes();
        reset_n = 0;
        repeat (2) @(posedge clk);
        #1;
        expect_bus("rst_idle_bus", 32'h0);
        pc_out = 1;
        expect_bus("rst_pc", 32'h0);
        clear_strobes(); z_low_out = 1;
        expect_bus("rst_z_low", 32'h0);
        clear_strobes(); z_high_out = 1;
        expect_bus("rst_z_high", 32'h0);
        reset_n = 1;
        clear_strobes();
        @(posedge clk); #1;

        load_gpr(2, 32'h22);
        load_gpr(4, 32'h24);
        load_gpr(5, 32'h26);

        clear_strobes(); pc_out = 1; inc_pc = 1; alu_op = 4'd2; z_in = 1; mar_in = 1;
        apply_stimulus("fetch_1");
        check_output("fetch_mar", dut.mar_q, 32'h0);
        clear_strobes(); z_low_out = 1; pc_in = 1;
        apply_stimulus("fetch_2");
        clear_strobes(); pc_out = 1;
        expect_bus("fetch_pc", 32'h1);

        load_mdr(32'h4A92_0000);
        clear_strobes(); mdr_out = 1; ir_in = 1;
        apply_stimulus("ir_load");
        check_output("ir_value", dut.ir_q, 32'h4A92_0000);
        clear_strobes(); c_out = 1;
        expect_bus("ir_c_sext", 32'h0002_0000);

        clear_strobes(); gpr_out[2] = 1; y_in = 1;
        apply_stimulus("and_y");
        clear_strobes(); gpr_out[4] = 1; alu_op = 4'd0; z_in = 1;
        apply_stimulus("and_z");
        clear_strobes(); z_low_out = 1; gpr_in[5] = 1;
        apply_stimulus("and_r5");
        clear_strobes(); gpr_out[5] = 1;
        expect_bus("and_r5_value", 32'h20);

        clear_strobes(); gpr_out[2] = 1; pc_out = 1; mdr_out = 1;
        expect_bus("prio_gpr", 32'h22);

        load_y(32'hFFFF_FFFE);
        alu_from_mdr(4'd8, 32'h3);
        read_z("mul", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        load_y(32'h7);
        alu_from_mdr(4'd9, 32'h2);
        read_z("div", 32'h1, 32'h3);
        clear_strobes(); inport_out = 1; alu_op = 4'd9; z_in = 1;
        apply_stimulus("div0_op");
        read_z("div0", 32'h7, 32'h0);

        load_y(32'h8000_0001);
        alu_from_mdr(4'd4, 32'h1);
        read_z("shr", 32'h0, 32'h4000_0000);
        alu_from_mdr(4'd6, 32'h1);
        read_z("ror", 32'h0, 32'hC000_0000);
        alu_from_mdr(4'd7, 32'h1);
        read_z("rol", 32'h0, 32'h0000_0003);
        alu_from_mdr(4'd10, 32'h1);
        read_z("neg", 32'h0, 32'hFFFF_FFFF);

        clear_strobes(); z_high_out = 1; z_low_out = 1; pc_out = 1;
        expect_bus("prio_zhigh", 32'h0);

        clear_strobes(); pc_out = 1; inc_pc = 1; alu_op = 4'd2; z_in = 1; mar_in = 1;
        #2;
        reset_n = 0;
        model_reset();
        #1;
        check_output("midrst_pc", bus_data, 32'h0);
        @(posedge clk); #1;
        reset_n = 1;
        clear_strobes(); pc_out = 1;
        expect_bus("midrst_pc_hold", 32'h0);
        apply_stimulus("midrst_pc_tick");
        clear_strobes(); z_low_out = 1;
        expect_bus("midrst_z", 32'h0);
        clear_strobes(); gpr_out[5] = 1;
        expect_bus("midrst_r5", 32'h0);

        for (int n = 0; n < 400; n++) begin
            clear_strobes();
            drive_source(int'($urandom_range(0, 24)));
            if ($urandom_range(0, 3) == 0) drive_source(int'($urandom_range(0, 24)));
            gpr_in     = 16'($urandom & $urandom & $urandom);
            hi_in      = ($urandom_range(0, 3) == 0);
            lo_in      = ($urandom_range(0, 3) == 0);
            pc_in      = ($urandom_range(0, 3) == 0);
            ir_in      = ($urandom_range(0, 3) == 0);
            y_in       = ($urandom_range(0, 2) == 0);
            mar_in     = ($urandom_range(0, 3) == 0);
            mdr_in     = ($urandom_range(0, 1) == 0);
            z_in       = ($urandom_range(0, 1) == 0);
            read       = ($urandom_range(0, 1) == 0);
            inc_pc     = ($urandom_range(0, 4) == 0);
            m_data_in  = $urandom;
            alu_op     = 4'($urandom_range(0, 15));
            eb = model_bus();
            a  = inc_pc ? 32'd1 : m_y;
            if (alu_op == 4'd9 && a == 32'h8000_0000 && eb == 32'hFFFF_FFFF) alu_op = 4'd2;
            apply_stimulus("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
